// File: rtl/divider_seq_pkg.sv
// ============================================================================
//  Module      : divider_info (package)
//  Description : Shared state encoding and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_info;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    localparam int          DIV_ITERATIONS    = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage : divider_info

`default_nettype wire

// File: rtl/divider_seq_step.sv
// ============================================================================
//  Module      : divider_step
//  Description : One combinational restoring radix-2 division step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // The compare sees the full shifted value; when it succeeds the
    // difference is known to fit in WIDTH bits, so a WIDTH-bit subtract suffices.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, dvsr});
    assign w_diff   = w_shift[WIDTH-1:0] - dvsr;
    assign next_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], w_ge};

endmodule : divider_step

`default_nettype wire

// File: rtl/divider_seq.sv
// ============================================================================
//  Module      : divider_seq
//  Description : 34-cycle signed/unsigned restoring divider with clear/hold.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_seq
    import divider_info::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             clear,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                  c_cnt_w      = $clog2(DIV_ITERATIONS);
    localparam logic [c_cnt_w-1:0]  c_count_init = c_cnt_w'(DIV_ITERATIONS - 1);

    div_state_t         r_state;
    div_state_t         w_next_state;
    logic               w_accept;

    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr_mag;
    logic [WIDTH-1:0]   r_dividend_raw;
    logic               r_res_neg;
    logic               r_dvd_neg;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_next_rem;
    logic [WIDTH-1:0]   w_next_quo;
    logic [WIDTH-1:0]   w_fix_quo;
    logic [WIDTH-1:0]   w_fix_rem;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

    divider_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .dvsr     (r_dvsr_mag),
        .next_rem (w_next_rem),
        .next_quo (w_next_quo)
    );

    // A zero divisor returns all-ones / raw dividend regardless of signedness.
    assign w_fix_quo = r_div_zero ? DIV_ZERO_QUOTIENT
                     : (r_res_neg ? -r_quo : r_quo);
    assign w_fix_rem = r_div_zero ? r_dividend_raw
                     : (r_dvd_neg ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (r_count == '0) begin
                    w_next_state = FIXUP;
                end
            end
            FIXUP: begin
                busy         = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!hold) begin
                    if (start) begin
                        w_accept     = 1'b1;
                        w_next_state = DIVIDE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (clear) begin
            w_next_state = IDLE;
            w_accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_dvsr_mag     <= '0;
            r_dividend_raw <= '0;
            r_res_neg      <= 1'b0;
            r_dvd_neg      <= 1'b0;
            r_div_zero     <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
        end else if (clear) begin
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_count        <= c_count_init;
            r_rem          <= '0;
            r_quo          <= w_dvd_mag;
            r_dvsr_mag     <= w_dvs_mag;
            r_dividend_raw <= dividend;
            r_res_neg      <= w_dvd_neg ^ w_dvs_neg;
            r_dvd_neg      <= w_dvd_neg;
            r_div_zero     <= (divisor == '0);
        end else if (r_state == DIVIDE) begin
            r_rem   <= w_next_rem;
            r_quo   <= w_next_quo;
            r_count <= r_count - 1'b1;
        end else if (r_state == FIXUP) begin
            r_quotient  <= w_fix_quo;
            r_remainder <= w_fix_rem;
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule : divider_seq

`default_nettype wire

// File: tb/tb_divider_seq.sv
// ============================================================================
//  Module      : tb_divider_seq
//  Description : Self-checking bench for divider_seq (table, corner, random).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_divider_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        clear = 1'b0;
    logic        hold = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_vec = 0;
    int n_err = 0;

    divider_seq #(
        .WIDTH     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .clear     (clear),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain language division plus the architectural special cases.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
        return {q, r};
    endfunction

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered just after the start edge; lat counts edges from start to the
    // edge that first samples done (34 expected).
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        lat = lat + 1;
    endtask

    task automatic run_vec(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int bcnt;
        issue(sgn, a, b);
        wait_done(lat, bcnt);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " latency"}, 32'(lat), 32'd34);
        check({tag, " busy cycles"}, 32'(bcnt), 32'd33);
        check({tag, " busy with done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        int ndone;
        logic [63:0] exp;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        tbl[3]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        tbl[4]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        tbl[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[7]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        tbl[9]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
        tbl[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
        tbl[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
        end

        // Hold across completion, then release with a back-to-back start.
        hold = 1'b1;
        issue(1'b0, 32'd1000, 32'd3);
        wait_done(lat, bcnt);
        check("hold latency", 32'(lat), 32'd34);
        for (int k = 0; k < 5; k++) begin
            check("hold done", 32'(done), 32'd1);
            check("hold quotient", quotient, 32'd333);
            check("hold remainder", remainder, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        hold      = 1'b0;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'hFFFF_FF9C;
        divisor   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b done falls", 32'(done), 32'd0);
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b old quotient kept", quotient, 32'd333);
        wait_done(lat, bcnt);
        check("b2b latency", 32'(lat), 32'd34);
        check("b2b quotient", quotient, 32'hFFFF_FFF5);
        check("b2b remainder", remainder, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

        // Clear during DIVIDE wins over a simultaneous start.
        issue(1'b0, 32'd5000, 32'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        clear    = 1'b1;
        start    = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd10;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        check("clear busy", 32'(busy), 32'd0);
        check("clear done", 32'(done), 32'd0);
        check("clear quotient", quotient, 32'd0);
        check("clear remainder", remainder, 32'd0);
        run_vec("after clear", 1'b0, 32'd999, 32'd10, 32'd99, 32'd9);

        // A start during DIVIDE is ignored and yields no second result.
        issue(1'b0, 32'd200, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ignored start quotient", quotient, 32'd22);
        check("ignored start remainder", remainder, 32'd2);
        ndone = 0;
        @(posedge clk);
        #1;
        repeat (40) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("ignored start no extra done", 32'(ndone), 32'd0);

        // Reset while in FIXUP restores reset values and drops the result.
        issue(1'b0, 32'd123456, 32'd7);
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        check("pre-reset busy in fixup", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("fixup reset busy", 32'(busy), 32'd0);
        check("fixup reset done", 32'(done), 32'd0);
        check("fixup reset quotient", quotient, 32'd0);
        check("fixup reset remainder", remainder, 32'd0);
        ndone = 0;
        repeat (40) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("fixup reset no done", 32'(ndone), 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic        sgn;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: b = $urandom;
            endcase
            exp = ref_div(sgn, a, b);
            run_vec($sformatf("rand%0d", i), sgn, a, b, exp[63:32], exp[31:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_seq

`default_nettype wire
